// File: rtl/riscv_div_unit.sv
// riscv_div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU unit.
// Radix-2 restoring division, one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: finish in one edge when |dividend| < |divisor|.
module riscv_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            reg_write,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CntLast = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            is_rem_q, is_rem_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] quo_nx, rem_nx, quo_fin, rem_fin;

  // Operand decode at accept: magnitudes and special-case detection.
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & rs1_data[XLEN-1];
    b_neg     = is_signed & rs2_data[XLEN-1];
    a_mag     = a_neg ? (~rs1_data + 1'b1) : rs1_data;
    b_mag     = b_neg ? (~rs2_data + 1'b1) : rs2_data;
    div_zero  = (rs2_data == '0);
    ovf       = is_signed & (rs1_data == MinNeg) & (rs2_data == '1);
  end

  // One restoring step; the XLEN+1-bit difference sign decides the quotient bit.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (diff[XLEN]) begin
      rem_nx = rem_sh[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_nx = diff[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b1};
    end
    quo_fin = negq_q ? (~quo_nx + 1'b1) : quo_nx;
    rem_fin = negr_q ? (~rem_nx + 1'b1) : rem_nx;
  end

  // Next-state logic for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    is_rem_d = is_rem_q;
    rd_d     = rd_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rd_d     = rd_in;
          is_rem_d = op[1];
          negq_d   = a_neg ^ b_neg;
          negr_d   = a_neg;
          quo_d    = a_mag;
          dvs_d    = b_mag;
          rem_d    = '0;
          cnt_d    = '0;
          if (div_zero) begin
            state_d  = StDone;
            result_d = op[1] ? rs1_data : '1;
          end else if (ovf) begin
            state_d  = StDone;
            result_d = op[1] ? '0 : rs1_data;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (a_mag < b_mag) begin
            state_d  = StDone;
            result_d = op[1] ? rs1_data : '0;
          end
`endif
          else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          result_d = is_rem_q ? rem_fin : quo_fin;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      is_rem_q <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      is_rem_q <= is_rem_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign reg_write = done;
  assign rd_out    = rd_q;
  assign result    = result_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed self-checking bench for riscv_div_unit (XLEN = 32).
module tb_riscv_div_unit;

  localparam int LatN = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int LatE = 1;
`else
  localparam int LatE = 33;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, reg_write;
  logic [4:0]  rd_out;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  riscv_div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .op        (op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .reg_write (reg_write),
    .rd_out    (rd_out),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble operands after accept, wait for done (bounded).
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd,
                     input logic [31:0] exp_res, input int exp_lat);
    int lat, busyc;
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    lat = 1;
    busyc = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy === 1'b1) busyc++;
    chk({tag, " result"}, result, exp_res);
    chk({tag, " rd_out"}, 32'(rd_out), 32'(rd));
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(busyc), 32'(exp_lat));
    chk({tag, " reg_write"}, 32'(reg_write), 32'd1);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    logic seen;
    // Reset state
    #1 rstn = 1'b0;
    #10;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst reg_write", 32'(reg_write), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst rd_out", 32'(rd_out), 32'd0);
    @(negedge clk) rstn = 1'b1;

    // Normal path, signed/unsigned variants
    run("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, LatN);
    run("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, LatN);
    run("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, LatN);
    run("remu_fff9_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'd1, LatN);
    run("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFD, LatN);
    run("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'd1, LatN);
    run("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'hFFFF_FFFF, LatN);

    // Divide by zero and signed overflow
    run("div_5_0", 2'b00, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 1);
    run("rem_5_0", 2'b10, 32'd5, 32'd0, 5'd8, 32'd5, 1);
    run("divu_0_0", 2'b01, 32'd0, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
    run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
    run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1);

    // Small dividend: early-out candidate
    run("divu_3_10", 2'b01, 32'd3, 32'd10, 5'd12, 32'd0, LatE);
    run("remu_3_10", 2'b11, 32'd3, 32'd10, 5'd13, 32'd3, LatE);
    run("div_m3_10", 2'b00, 32'hFFFF_FFFD, 32'd10, 5'd14, 32'd0, LatE);
    run("rem_m3_10", 2'b10, 32'hFFFF_FFFD, 32'd10, 5'd15, 32'hFFFF_FFFD, LatE);

    // start re-asserted during CALC is ignored
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b00; rs1_data = 32'd50; rs2_data = 32'd5; rd_in = 5'd9;
    repeat (2) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ignore_start done_seen", 32'(done), 32'd1);
    chk("ignore_start result", result, 32'd14);
    chk("ignore_start rd_out", 32'(rd_out), 32'd3);
    @(posedge clk); #1;
    chk("ignore_start idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd21;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort rd_out", 32'(rd_out), 32'd0);
    @(negedge clk) rstn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    chk("abort no_done", 32'(seen), 32'd0);
    run("divu_9_3", 2'b01, 32'd9, 32'd3, 5'd17, 32'd3, LatN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
